// File: rtl/std_shift_serializer_pkg.sv
// Shared types and helpers for the std_shift_serializer block.
// Optional parity output is controlled by STD_SHIFT_SERIALIZER_PARITY_EN (see top).
package std_shift_serializer_pkg;

  typedef logic [7:0] std_clock_info_t;

  typedef enum logic {
    STD_SER_IDLE,
    STD_SER_SHIFT
  } std_shift_serializer_state_t;

  // A zero or oversized request means "emit the whole word".
  function automatic int std_ser_eff_count(input int count, input int n);
    return (count == 0 || count >= n) ? n : count;
  endfunction

endpackage

// File: rtl/std_register.sv
// Plain D register with asynchronous active-low reset to zero.
module std_register
  import std_shift_serializer_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO = 'b0,
  parameter int              WIDTH      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (WIDTH < 1 || $bits(CLOCK_INFO) < 1) begin : g_bad_cfg
    $error("std_register: invalid configuration");
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= d;
  end

endmodule

// File: rtl/std_shift_serializer.sv
// Parallel-in / serial-out symbol shifter with valid/ready on both sides.
// Define STD_SHIFT_SERIALIZER_PARITY_EN to add the out_parity output.
module std_shift_serializer
  import std_shift_serializer_pkg::*;
#(
  parameter std_clock_info_t CLOCK_INFO   = 'b0,
  parameter int              DATA_WIDTH   = 32,
  parameter int              SYMBOL_WIDTH = 8,
  parameter bit              MSB_FIRST    = 1'b1,
  localparam int             N_SYMBOLS    = DATA_WIDTH / SYMBOL_WIDTH,
  localparam int             CNT_W        = $clog2(N_SYMBOLS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [CNT_W-1:0]        in_count,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy
`ifdef STD_SHIFT_SERIALIZER_PARITY_EN
  ,
  output logic                    out_parity
`endif
);

  if (SYMBOL_WIDTH < 1 || (DATA_WIDTH % SYMBOL_WIDTH) != 0) begin : g_bad_width
    $error("std_shift_serializer: SYMBOL_WIDTH must divide DATA_WIDTH");
  end

  std_shift_serializer_state_t state, state_next;
  logic                  state_bits;
  logic [DATA_WIDTH-1:0] shreg, shreg_next;
  logic [CNT_W-1:0]      remaining, remaining_next;
  logic                  accept, beat;

  std_register #(.CLOCK_INFO(CLOCK_INFO), .WIDTH(1)) u_state_reg (
    .clk (clk),
    .rst (rst),
    .d   (state_next),
    .q   (state_bits)
  );

  std_register #(.CLOCK_INFO(CLOCK_INFO), .WIDTH(DATA_WIDTH)) u_data_reg (
    .clk (clk),
    .rst (rst),
    .d   (shreg_next),
    .q   (shreg)
  );

  std_register #(.CLOCK_INFO(CLOCK_INFO), .WIDTH(CNT_W)) u_count_reg (
    .clk (clk),
    .rst (rst),
    .d   (remaining_next),
    .q   (remaining)
  );

  assign state     = std_shift_serializer_state_t'(state_bits);
  assign busy      = (state == STD_SER_SHIFT);
  assign out_valid = busy;
  assign out_last  = busy && (remaining == CNT_W'(1));
  assign out_data  = MSB_FIRST ? shreg[DATA_WIDTH-1 -: SYMBOL_WIDTH]
                               : shreg[SYMBOL_WIDTH-1:0];

  // rst gating keeps in_ready low while the engine is held in reset.
  assign in_ready = rst && !clear && ((state == STD_SER_IDLE) || (out_ready && out_last));
  assign accept   = in_valid && in_ready;
  assign beat     = out_valid && out_ready;

`ifdef STD_SHIFT_SERIALIZER_PARITY_EN
  assign out_parity = busy & (^out_data);
`endif

  always_comb begin
    state_next     = state;
    shreg_next     = shreg;
    remaining_next = remaining;
    if (clear) begin
      state_next     = STD_SER_IDLE;
      shreg_next     = '0;
      remaining_next = '0;
    end else begin
      if (beat) begin
        shreg_next = MSB_FIRST ? (shreg << SYMBOL_WIDTH) : (shreg >> SYMBOL_WIDTH);
        if (remaining != '0) remaining_next = remaining - CNT_W'(1);
        // Leftover bits of a truncated word are discarded on the final beat.
        if (out_last) begin
          state_next = STD_SER_IDLE;
          shreg_next = '0;
        end
      end
      if (accept) begin
        state_next     = STD_SER_SHIFT;
        shreg_next     = in_data;
        remaining_next = CNT_W'(std_ser_eff_count(int'(in_count), N_SYMBOLS));
      end
    end
  end

endmodule

// File: doc/std_shift_serializer.md
Name: std_shift_serializer

Overview:
- Parametrised parallel-in / serial-out shift engine.
- Generalises the single-bit shift register to multi-bit symbols, selectable shift direction and variable-length words.
- Valid/ready handshakes on both sides.
- Sits between word-wide datapaths and narrow serial links (UART/SPI/byte-stream framers) in the std library.

Parameters:
- CLOCK_INFO, 'b0, std_clock_info_t clock descriptor, passed to register instances
- DATA_WIDTH, 32, parallel word width in bits
- SYMBOL_WIDTH, 8, bits emitted per output beat; must divide DATA_WIDTH exactly (elaboration error otherwise)
- MSB_FIRST, 1, 1 = most-significant symbol first; 0 = least-significant first
- N_SYMBOLS (localparam), DATA_WIDTH/SYMBOL_WIDTH
- CNT_W (localparam), $clog2(N_SYMBOLS+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- clear  in  1  synchronous abort; drops the current word
- in_valid  in  1  parallel word offered
- in_ready  out  1  engine accepts word this cycle
- in_data  in  DATA_WIDTH  parallel word
- in_count  in  CNT_W  symbols to emit; 0 or values >= N_SYMBOLS mean N_SYMBOLS
- out_valid  out  1  symbol available
- out_ready  in  1  consumer accepts symbol
- out_data  out  SYMBOL_WIDTH  current symbol
- out_last  out  1  current symbol is the final one of its word
- busy  out  1  word in flight

Interface: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, shift register 0, remaining count 0.
  - Outputs during reset: out_valid=0, out_last=0, busy=0, in_ready=0, out_data=0.
  - in_ready is 1 from the first clock edge after reset deassertion.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: out_valid=1.
- Accept: in_valid && in_ready at an edge.
  - Loads in_data into the shift register and the effective count into remaining.
  - Next state SHIFT.
  - First symbol is valid the cycle after acceptance (1-cycle latency).
- Output symbol selection:
  - MSB_FIRST=1: out_data = reg[DATA_WIDTH-1 -: SYMBOL_WIDTH]; the register shifts left by SYMBOL_WIDTH, zero-filled.
  - MSB_FIRST=0: out_data = reg[SYMBOL_WIDTH-1:0]; the register shifts right, zero-filled.
- Out beat: on out_valid && out_ready, shift and decrement remaining.
  - out_last = (remaining == 1).
  - When the last beat fires, the next state is IDLE unless a new word is accepted in the same cycle.
- Back-to-back: in SHIFT, in_ready = out_ready && out_last.
  - A word accepted on the last-beat edge loads directly and stays in SHIFT.
  - Zero bubble between words.
- Backpressure: while out_valid && !out_ready, out_data, out_last and remaining hold stable.
- Truncated words:
  - in_count=k < N_SYMBOLS emits exactly k symbols, taken from the first-out end.
  - The remaining bits are discarded.
- busy = (state == SHIFT).
- clear (synchronous, highest priority after reset):
  - Next state IDLE, remaining 0, register 0.
  - Any simultaneous in/out handshake is ignored.
  - in_ready is forced 0 while clear=1.
- Reset mid-word: word is lost; no partial output after release.
- Counter never wraps: remaining is only decremented when nonzero.

Optional Feature:
- Macro: STD_SHIFT_SERIALIZER_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = XOR reduction of out_data (even parity), combinational from the register.
  - out_parity is 0 in reset and IDLE.
  - Stable under backpressure, like out_data.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- std_pkg additions:
  - typedef enum logic {STD_SER_IDLE, STD_SER_SHIFT} std_shift_serializer_state_t.
  - Helper function std_ser_eff_count(count, n) returning the clamped effective count.
- Sub-module: std_register, three instances (state, shift data, remaining count).
  - All next-state logic lives in one always_comb in this module.
  - No new sub-module.

Test Plan (DATA_WIDTH=32, SYMBOL_WIDTH=8 unless noted):
- MSB_FIRST=1; load 0xA1B2C3D4, count 0; out_ready=1 -> out_data A1,B2,C3,D4 on 4 consecutive cycles starting 1 cycle after accept; out_last only on D4; busy falls after D4.
- MSB_FIRST=0; same word -> D4,C3,B2,A1; count=2 -> D4,C3 only, out_last on C3.
- Backpressure: out_ready low 3 cycles on second beat -> B2 and out_last=0 held stable; no symbol lost or duplicated.
- Back-to-back: second word 0x11223344 presented continuously -> in_ready pulses on the D4 beat; next cycle shows 11 with no gap; 8 contiguous beats total.
- Abort: clear asserted on the B2 beat with in_valid=1 -> out_valid 0 next cycle, word not accepted; a fresh load of 0x55667788 then emits 55 first.
- Reset mid-word after A1: rst low async -> out_valid/busy drop immediately; after release, idle with in_ready=1. PARITY_EN build: 0x07 gives out_parity=1, 0x03 gives out_parity=0.
